// File: rtl/dcache_port_arbn_pkg.sv
// dcache_port_arbn_pkg: request codes, arbiter state encoding and index helpers for the D-cache port arbiter
package dcache_port_arbn_pkg;

    // Request codes carried on req_type / cache_request
    typedef enum logic [3:0] {
        C_REQ_NONE     = 4'd0,
        C_REQ_LOAD     = 4'd1,
        C_REQ_STORE    = 4'd2,
        C_REQ_PTW      = 4'd3,
        C_REQ_PREFETCH = 4'd4,
        C_REQ_FLUSH    = 4'd5
    } c_req_e;

    // Arbiter FSM: IDLE picks a winner each cycle, BUSY holds the grant until completion or abort
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Next port index after i, wrapping n-1 back to 0
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/dcache_port_arbn_if.sv
// dcache_port_arbn_if: flattened requester bus plus the single cache primary port
interface dcache_port_arbn_if #(
    parameter int NR_PORTS = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [NR_PORTS-1:0]        req_strobe;
    logic [NR_PORTS*ADDR_W-1:0] req_addr;
    logic [NR_PORTS*4-1:0]      req_type;
    logic [NR_PORTS*2-1:0]      req_size;
    logic [NR_PORTS*DATA_W-1:0] req_wdata;
    logic [NR_PORTS-1:0]        req_valid;
    logic [ADDR_W-1:0]          cache_address;
    logic [3:0]                 cache_request;
    logic [1:0]                 cache_size;
    logic [DATA_W-1:0]          cache_wdata;
    logic                       cache_strobe;
    logic                       cache_stall;
    logic                       cache_valid;

    // Requesters and the cache together
    modport master (
        output req_strobe, req_addr, req_type, req_size, req_wdata, cache_stall, cache_valid,
        input  req_valid, cache_address, cache_request, cache_size, cache_wdata, cache_strobe
    );

    // The arbiter
    modport slave (
        input  req_strobe, req_addr, req_type, req_size, req_wdata, cache_stall, cache_valid,
        output req_valid, cache_address, cache_request, cache_size, cache_wdata, cache_strobe
    );
endinterface

// File: rtl/dcache_port_arbn_prio_pick.sv
// dcache_port_arbn_prio_pick: rotating-priority picker with promotion override, purely combinational
module dcache_port_arbn_prio_pick #(
    parameter int  N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  promote,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW-1:0] pidx;
    logic [IW:0]   sum;

    // Rotate so start sits at bit 0, take the first set bit, then rotate the index back; promotion wins outright
    always_comb begin
        rot  = N'({req, req} >> start);
        off  = '0;
        pidx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
            if (promote[i]) pidx = IW'(i);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx   = (|promote) ? pidx : sum[IW-1:0];
        any   = |req;
        grant = any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/dcache_port_arbn.sv
// dcache_port_arbn: N-port arbiter in front of the D-cache primary port with grant hold and starvation promotion
module dcache_port_arbn
    import dcache_port_arbn_pkg::*;
#(
    parameter int  NR_PORTS  = 3,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  RR_MODE   = 0,
    parameter int  MAX_WAIT  = 15,
    parameter int  FAST_PORT = 1,
    localparam int IW        = $clog2(NR_PORTS)
) (
    input  logic               clk,
    input  logic               reset,
    dcache_port_arbn_if.slave  bus,
    output logic [IW-1:0]      owner,
    output logic               busy
);
    arb_state_t          state, state_nx;
    logic [IW-1:0]       rr_ptr, pick_idx, sel, start_idx;
    logic [NR_PORTS-1:0] promote, pick_oh, rv;
    logic                pick_any, done, grant, fin;
    logic [ADDR_W-1:0]   addr_a [NR_PORTS];
    logic [3:0]          type_a [NR_PORTS];
    logic [1:0]          size_a [NR_PORTS];
    logic [DATA_W-1:0]   wdata_a [NR_PORTS];

    for (genvar i = 0; i < NR_PORTS; i++) begin : g_port
        logic [7:0] cnt;
        assign addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign type_a[i]  = bus.req_type[i*4 +: 4];
        assign size_a[i]  = bus.req_size[i*2 +: 2];
        assign wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
        assign promote[i] = (RR_MODE == 0) && bus.req_strobe[i] && (cnt == 8'(MAX_WAIT));
        // Count grants lost while pending; cleared when this port wins or stops requesting
        always_ff @(posedge clk or negedge reset)
            if (!reset) cnt <= '0;
            else if (RR_MODE != 0 || !bus.req_strobe[i] || (grant && pick_idx == IW'(i))) cnt <= '0;
            else if (grant && cnt != 8'(MAX_WAIT)) cnt <= cnt + 8'd1;
    end

    assign start_idx = (RR_MODE != 0) ? rr_ptr : '0;

    dcache_port_arbn_prio_pick #(.N(NR_PORTS)) u_pick (
        .req     (bus.req_strobe),
        .start   (start_idx),
        .promote (promote),
        .grant   (pick_oh),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign done  = bus.cache_valid && !bus.cache_stall;
    assign grant = (state == ARB_IDLE) && pick_any;
    assign busy  = (state == ARB_BUSY);
    assign sel   = busy ? owner : pick_any ? pick_idx : IW'(FAST_PORT);

    // Completion pulse goes to the owner only while it still strobes; idle completion goes to the fresh winner
    always_comb begin
        rv = '0;
        if (reset && done) rv = busy ? (bus.req_strobe[owner] ? NR_PORTS'(1) << owner : '0) : pick_oh;
    end

    assign fin                = |rv;
    assign bus.req_valid      = rv;
    assign bus.cache_strobe   = reset && (busy ? bus.req_strobe[owner] : pick_any);
    assign bus.cache_address  = reset ? addr_a[sel] : addr_a[FAST_PORT];
    assign bus.cache_request  = reset ? type_a[sel] : '0;
    assign bus.cache_size     = reset ? size_a[sel] : '0;
    assign bus.cache_wdata    = reset ? wdata_a[sel] : '0;

    // Next state: a grant without same-cycle completion locks the port; completion or abort releases it
    always_comb begin
        state_nx = state;
        if (state == ARB_IDLE) state_nx = (pick_any && !done) ? ARB_BUSY : ARB_IDLE;
        else state_nx = (!bus.req_strobe[owner] || done) ? ARB_IDLE : ARB_BUSY;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= ARB_IDLE;
        else state <= state_nx;

    // Latch every winner; in round-robin mode move the search start past whoever just completed
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant) owner <= pick_idx;
            if (RR_MODE != 0 && fin) rr_ptr <= IW'(wrap_inc(int'(sel), NR_PORTS));
        end
endmodule

// File: tb/tb_dcache_port_arbn.sv
// tb_dcache_port_arbn: fixed-priority and round-robin arbiters checked against a transaction-level model
module tb_dcache_port_arbn;
    import dcache_port_arbn_pkg::*;

    localparam int N = 3, AW = 32, DW = 32, MAXW = 2, FAST = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dcache_port_arbn_if #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bf ();
    dcache_port_arbn_if #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) br ();
    logic [1:0] own_f, own_r;
    logic       busy_f, busy_r;

    dcache_port_arbn #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_WAIT(MAXW), .FAST_PORT(FAST))
        dut_f (.clk(clk), .reset(reset), .bus(bf.slave), .owner(own_f), .busy(busy_f));
    dcache_port_arbn #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_WAIT(15), .FAST_PORT(FAST))
        dut_r (.clk(clk), .reset(reset), .bus(br.slave), .owner(own_r), .busy(busy_r));

    logic [N-1:0]    strb [2];
    logic [N*AW-1:0] addr [2];
    logic [N*4-1:0]  typ  [2];
    logic [N*2-1:0]  sz   [2];
    logic [N*DW-1:0] wd   [2];
    logic            cv   [2];
    logic            cs   [2];
    logic [N-1:0]    persist [2];

    assign bf.req_strobe = strb[0];
    assign bf.req_addr = addr[0];
    assign bf.req_type = typ[0];
    assign bf.req_size = sz[0];
    assign bf.req_wdata = wd[0];
    assign bf.cache_valid = cv[0];
    assign bf.cache_stall = cs[0];
    assign br.req_strobe = strb[1];
    assign br.req_addr = addr[1];
    assign br.req_type = typ[1];
    assign br.req_size = sz[1];
    assign br.req_wdata = wd[1];
    assign br.cache_valid = cv[1];
    assign br.cache_stall = cs[1];

    int m_own [2];
    int m_last [2];
    int m_ptr [2];
    int m_wait [2][N];
    logic [N-1:0] e_rv [2];
    logic [N-1:0] obs_rv [2];
    logic obs_stb [2];
    logic obs_busy [2];
    int lg0[$], lg1[$];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int q2n(input int q[$]);
        int v = 1;
        foreach (q[k]) v = v * 16 + q[k];
        return v;
    endfunction

    function automatic int winner(input int d);
        if (d == 1) begin
            for (int k = 0; k < N; k++) if (strb[d][(m_ptr[d] + k) % N]) return (m_ptr[d] + k) % N;
        end else begin
            for (int i = 0; i < N; i++) if (strb[d][i] && m_wait[d][i] == MAXW) return i;
            for (int i = 0; i < N; i++) if (strb[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input int d);
        int w, sel;
        logic dn, stb;
        logic [N-1:0] rv, o_rv;
        logic [AW+4+2+DW-1:0] ef, of;
        logic o_stb, o_busy;
        logic [1:0] o_own;
        string p;
        p = d ? "rr" : "fix";
        w = (m_own[d] < 0) ? winner(d) : -1;
        sel = (m_own[d] >= 0) ? m_own[d] : (w >= 0) ? w : FAST;
        dn = cv[d] && !cs[d];
        rv = '0;
        if (reset && dn && m_own[d] >= 0 && strb[d][m_own[d]]) rv[m_own[d]] = 1'b1;
        if (reset && dn && m_own[d] < 0 && w >= 0) rv[w] = 1'b1;
        stb = reset && ((m_own[d] >= 0) ? strb[d][m_own[d]] : (w >= 0));
        ef = reset ? {addr[d][sel*AW +: AW], typ[d][sel*4 +: 4], sz[d][sel*2 +: 2], wd[d][sel*DW +: DW]}
                   : {addr[d][FAST*AW +: AW], 4'd0, 2'd0, {DW{1'b0}}};
        o_rv = d ? br.req_valid : bf.req_valid;
        o_stb = d ? br.cache_strobe : bf.cache_strobe;
        o_busy = d ? busy_r : busy_f;
        o_own = d ? own_r : own_f;
        of = d ? {br.cache_address, br.cache_request, br.cache_size, br.cache_wdata}
               : {bf.cache_address, bf.cache_request, bf.cache_size, bf.cache_wdata};
        chk({p, ".req_valid"}, o_rv, rv);
        chk({p, ".cache_strobe"}, o_stb, stb);
        chk({p, ".busy"}, o_busy, reset && m_own[d] >= 0);
        chk({p, ".owner"}, o_own, reset ? m_last[d] : 0);
        chk({p, ".cache_fields"}, of, ef);
        e_rv[d] = rv;
        obs_rv[d] = o_rv;
        obs_stb[d] = o_stb;
        obs_busy[d] = o_busy;
        for (int i = 0; i < N; i++) if (o_rv[i]) begin
            if (d) lg1.push_back(i); else lg0.push_back(i);
        end
    endtask

    task automatic update(input int d);
        int w;
        logic dn;
        if (!reset) begin
            m_own[d] = -1;
            m_last[d] = 0;
            m_ptr[d] = 0;
            for (int i = 0; i < N; i++) m_wait[d][i] = 0;
            return;
        end
        w = (m_own[d] < 0) ? winner(d) : -1;
        dn = cv[d] && !cs[d];
        if (w >= 0) begin
            for (int i = 0; i < N; i++)
                m_wait[d][i] = (!strb[d][i] || i == w) ? 0 : (m_wait[d][i] + 1 > MAXW) ? MAXW : m_wait[d][i] + 1;
            m_last[d] = w;
            if (dn) m_ptr[d] = (w + 1) % N;
            else m_own[d] = w;
        end else begin
            for (int i = 0; i < N; i++) if (!strb[d][i]) m_wait[d][i] = 0;
            if (m_own[d] >= 0) begin
                if (!strb[d][m_own[d]]) m_own[d] = -1;
                else if (dn) begin
                    m_ptr[d] = (m_own[d] + 1) % N;
                    m_own[d] = -1;
                end
            end
        end
    endtask

    task automatic new_req(input int d, input int i);
        strb[d][i] = 1'b1;
        addr[d][i*AW +: AW] = $urandom;
        typ[d][i*4 +: 4] = 4'($urandom_range(int'(C_REQ_NONE), int'(C_REQ_FLUSH)));
        sz[d][i*2 +: 2] = 2'($urandom);
        wd[d][i*DW +: DW] = $urandom;
    endtask

    task automatic req_both(input int i);
        new_req(0, i);
        new_req(1, i);
    endtask

    task automatic set_cache(input logic v, input logic s);
        cv[0] = v;
        cv[1] = v;
        cs[0] = s;
        cs[1] = s;
    endtask

    task automatic cycle();
        @(negedge clk);
        check(0);
        check(1);
        @(posedge clk);
        update(0);
        update(1);
        #1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) if (e_rv[d][i]) begin
                strb[d][i] = 1'b0;
                if (persist[d][i]) new_req(d, i);
            end
    endtask

    task automatic op(input int lat);
        repeat (lat) begin
            set_cache(1'b0, 1'b1);
            cycle();
        end
        set_cache(1'b1, 1'b0);
        cycle();
        set_cache(1'b0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1;
            m_last[d] = 0;
            m_ptr[d] = 0;
            for (int i = 0; i < N; i++) begin
                m_wait[d][i] = 0;
                new_req(d, i);
            end
            strb[d] = '0;
            persist[d] = '0;
            e_rv[d] = '0;
        end
        set_cache(1'b0, 1'b0);
        repeat (2) cycle();
        chk("reset.strobe", {bf.cache_strobe, br.cache_strobe}, 2'b00);
        chk("reset.address", bf.cache_address, addr[0][FAST*AW +: AW]);
        #2 reset = 1'b1;

        // Three simultaneous requests, 3 stall cycles each
        lg0.delete(); lg1.delete();
        for (int i = 0; i < N; i++) req_both(i);
        repeat (3) op(3);
        chk("t1.fix_order", q2n(lg0), 'h1012);
        chk("t1.rr_order", q2n(lg1), 'h1012);

        // Continuous strobing on all ports, 1-cycle cache
        lg0.delete(); lg1.delete();
        persist[0] = '1;
        persist[1] = '1;
        for (int i = 0; i < N; i++) req_both(i);
        repeat (6) op(1);
        persist[0] = '0;
        persist[1] = '0;
        strb[0] = '0;
        strb[1] = '0;
        chk("t2.rr_order", q2n(lg1), 'h1012012);
        chk("t3.fix_starve_order", q2n(lg0), 'h1001201);

        // Stray cache_valid with nobody requesting
        set_cache(1'b1, 1'b0);
        cycle();
        chk("idle_valid.rv", {obs_rv[0], obs_rv[1]}, 6'b0);

        // Zero-latency hit, then back-to-back
        req_both(2);
        cycle();
        chk("t4.rv_same_cycle", {obs_rv[0], obs_rv[1]}, 6'b100_100);
        chk("t4.busy", {obs_busy[0], obs_busy[1]}, 2'b00);
        req_both(0);
        cycle();
        chk("t4.back_to_back", {obs_rv[0], obs_rv[1]}, 6'b001_001);
        set_cache(1'b0, 1'b0);

        // Abort in the second BUSY cycle
        req_both(1);
        cycle();
        cycle();
        strb[0][1] = 1'b0;
        strb[1][1] = 1'b0;
        req_both(2);
        set_cache(1'b1, 1'b0);
        cycle();
        chk("t5.abort_strobe", {obs_stb[0], obs_stb[1]}, 2'b00);
        chk("t5.abort_rv", {obs_rv[0], obs_rv[1]}, 6'b0);
        set_cache(1'b0, 1'b0);
        cycle();
        chk("t5.next_grant", {obs_stb[0], obs_stb[1]}, 2'b11);
        set_cache(1'b1, 1'b0);
        cycle();
        chk("t5.port2_done", {obs_rv[0], obs_rv[1]}, 6'b100_100);
        set_cache(1'b0, 1'b0);

        // Async reset in the middle of a BUSY op
        req_both(2);
        cycle();
        cycle();
        #2 reset = 1'b0;
        set_cache(1'b1, 1'b0);
        #1;
        chk("t6.strobe", {bf.cache_strobe, br.cache_strobe}, 2'b00);
        chk("t6.rv", {bf.req_valid, br.req_valid}, 6'b0);
        chk("t6.busy", {busy_f, busy_r}, 2'b00);
        chk("t6.owner", {own_f, own_r}, 4'b0);
        chk("t6.fields", {bf.cache_request, bf.cache_size, bf.cache_wdata}, 0);
        chk("t6.address", bf.cache_address, addr[0][FAST*AW +: AW]);
        cycle();
        strb[0] = '0;
        strb[1] = '0;
        set_cache(1'b0, 1'b0);
        #2 reset = 1'b1;
        lg0.delete(); lg1.delete();
        req_both(0);
        op(2);
        chk("t6.after_release", {q2n(lg0), q2n(lg1)}, {32'h10, 32'h10});

        // Randomized traffic, cache timing and occasional reset pulses
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (!strb[d][i] && $urandom_range(0, 3) == 0) new_req(d, i);
                    else if (strb[d][i] && $urandom_range(0, 60) == 0) strb[d][i] = 1'b0;
                    if ($urandom_range(0, 40) == 0) persist[d][i] = ~persist[d][i];
                end
                cv[d] = ($urandom_range(0, 2) == 0);
                cs[d] = ($urandom_range(0, 3) == 0);
            end
            if (k % 800 == 400) #2 reset = 1'b0;
            if (k % 800 == 402) #2 reset = 1'b1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
